pll_profile_seq: RTL and testbench

Parametrised PLL reconfiguration sequencer that reprograms the system PLL through its Avalon-MM reconfiguration port to one of NUM_PROFILES clock profiles, such as native speed, 60 Hz adjust or further speed trims. It sits between the OSD status bits and the pll_cfg management port and runs on the 50 MHz reference clock. Its one job is to turn a profile index into a fully handshaked write sequence. While the PLL is being retimed it raises a hold request to the core pause logic, then waits for lock.

---
 rtl/pll_profile_seq.sv | 201 ++++++++++++++++++++
 tb/tb_pll_profile_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_profile_seq.sv
// rtl/pll_profile_seq.sv - PLL reconfiguration sequencer: profile index to handshaked write sequence
module pll_profile_seq #(
    parameter int NUM_PROFILES  = 4,
    parameter int INIT_PROFILE  = 0,
    parameter int SETTLE_CYCLES = 16,
    parameter int LOCK_MIN      = 64,
    parameter int LOCK_TIMEOUT  = 65536,
    localparam int PW           = $clog2(NUM_PROFILES)
) (
    input  logic                       clk_50m,
    input  logic                       reset,
    input  logic [PW-1:0]              profile_sel,
    input  logic [32*NUM_PROFILES-1:0] profile_k,
    input  logic                       locked,
    input  logic                       mgmt_waitrequest,
    output logic                       mgmt_write,
    output logic [5:0]                 mgmt_address,
    output logic [31:0]                mgmt_writedata,
    output logic                       busy,
    output logic                       hold,
    output logic [PW-1:0]              active_profile,
    output logic                       lock_error
);

    localparam int SW       = $clog2(SETTLE_CYCLES + 1);
    localparam int LOCK_MAX = (LOCK_MIN > LOCK_TIMEOUT) ? LOCK_MIN : LOCK_TIMEOUT;
    localparam int CW       = $clog2(LOCK_MAX + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] LOCKMIN_LAST = CW'(LOCK_MIN - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [PW-1:0] INIT_P = PW'(INIT_PROFILE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MODE,
        S_FRAC,
        S_START,
        S_LOCKMIN,
        S_LOCKWAIT,
        S_DONE
    } state_t;

    // K words unpacked into an array padded to a power of two so any index is in range
    logic [31:0] k_word [2**PW];

    for (genvar g = 0; g < 2**PW; g++) begin : g_kword
        if (g < NUM_PROFILES) begin : g_used
            assign k_word[g] = profile_k[32*g +: 32];
        end else begin : g_pad
            assign k_word[g] = 32'd0;
        end
    end

    logic [PW-1:0] sel_meta_q, sel_sync_q;
    logic [SW-1:0] stab_q, stab_d;
    logic [PW-1:0] req_q, req_d;
    logic          lock_meta_q, lock_sync_q;
    logic          sel_valid;

    state_t        state_q, state_d;
    logic [PW-1:0] tgt_q, tgt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] active_q, active_d;
    logic          lock_err_q, lock_err_d;
    logic          timed_out_q, timed_out_d;

    assign sel_valid = (32'(sel_sync_q) < 32'(NUM_PROFILES));

    // Synchronise the asynchronous inputs and hold the settled request
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            sel_meta_q  <= INIT_P;
            sel_sync_q  <= INIT_P;
            stab_q      <= '0;
            req_q       <= INIT_P;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            sel_meta_q  <= profile_sel;
            sel_sync_q  <= sel_meta_q;
            stab_q      <= stab_d;
            req_q       <= req_d;
            lock_meta_q <= locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Stability counter restarts on every synchronised change; req follows only settled, valid values
    always_comb begin
        stab_d = stab_q;
        req_d  = req_q;
        if (sel_meta_q != sel_sync_q) begin
            stab_d = '0;
        end else if (stab_q != SETTLE_LAST) begin
            stab_d = stab_q + SW'(1);
        end
        if (stab_q == SETTLE_LAST && sel_valid) begin
            req_d = sel_sync_q;
        end
    end

    // Sequencer state and bookkeeping registers
    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tgt_q       <= INIT_P;
            cnt_q       <= '0;
            active_q    <= INIT_P;
            lock_err_q  <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            lock_err_q  <= lock_err_d;
            timed_out_q <= timed_out_d;
        end
    end

    // Next-state logic and write-port decode; writes advance only on a cycle without waitrequest
    always_comb begin
        state_d        = state_q;
        tgt_d          = tgt_q;
        cnt_d          = cnt_q;
        active_d       = active_q;
        lock_err_d     = lock_err_q;
        timed_out_d    = timed_out_q;
        mgmt_write     = 1'b0;
        mgmt_address   = 6'd0;
        mgmt_writedata = 32'd0;
        busy           = (state_q != S_IDLE);
        hold           = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (req_q != active_q) begin
                    tgt_d   = req_q;
                    state_d = S_MODE;
                end
            end
            S_MODE: begin
                mgmt_write = 1'b1;
                if (!mgmt_waitrequest) begin
                    state_d = S_FRAC;
                end
            end
            S_FRAC: begin
                mgmt_write     = 1'b1;
                mgmt_address   = 6'd7;
                mgmt_writedata = k_word[tgt_q];
                if (!mgmt_waitrequest) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                mgmt_write   = 1'b1;
                mgmt_address = 6'd2;
                if (!mgmt_waitrequest) begin
                    cnt_d   = '0;
                    state_d = S_LOCKMIN;
                end
            end
            S_LOCKMIN: begin
                if (cnt_q == LOCKMIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOCKWAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOCKWAIT: begin
                if (lock_sync_q) begin
                    timed_out_d = 1'b0;
                    state_d     = S_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timed_out_d = 1'b1;
                    lock_err_d  = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                active_d = tgt_q;
                if (!timed_out_q) begin
                    lock_err_d = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign active_profile = active_q;
    assign lock_error     = lock_err_q;

endmodule

// File: tb/tb_pll_profile_seq.sv
// tb/tb_pll_profile_seq.sv - directed self-checking bench for pll_profile_seq
module tb_pll_profile_seq;

    localparam int NP = 3;
    localparam int SC = 4;
    localparam int LM = 8;
    localparam int LT = 20;
    localparam logic [31:0] K0 = 32'h1111_1111;
    localparam logic [31:0] K1 = 32'hC271_4BD9;
    localparam logic [31:0] K2 = 32'h0BAD_F00D;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  profile_sel;
    logic [95:0] profile_k;
    logic        locked;
    logic        mgmt_waitrequest;
    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        busy;
    logic        hold;
    logic [1:0]  active_profile;
    logic        lock_error;

    pll_profile_seq #(
        .NUM_PROFILES (NP),
        .INIT_PROFILE (0),
        .SETTLE_CYCLES(SC),
        .LOCK_MIN     (LM),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk_50m         (clk),
        .reset           (reset),
        .profile_sel     (profile_sel),
        .profile_k       (profile_k),
        .locked          (locked),
        .mgmt_waitrequest(mgmt_waitrequest),
        .mgmt_write      (mgmt_write),
        .mgmt_address    (mgmt_address),
        .mgmt_writedata  (mgmt_writedata),
        .busy            (busy),
        .hold            (hold),
        .active_profile  (active_profile),
        .lock_error      (lock_error)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  a;
        logic [31:0] d;
        int          c;
    } wr_t;

    wr_t wq[$];
    int  cyc = 0;
    int  busy_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b0 && mgmt_write === 1'b1 && mgmt_waitrequest === 1'b0)
            wq.push_back('{mgmt_address, mgmt_writedata, cyc});
        if (busy === 1'b1)
            busy_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_write(input string tag);
        int n = 0;
        while (mgmt_write !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        chk(tag, 32'(n < 100), 32'd1);
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            step(1);
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    task automatic check_seq(input string tag, input int base, input logic [31:0] k);
        if (wq.size() >= base + 3) begin
            chk({tag, "_a0"}, 32'(wq[base].a), 32'd0);
            chk({tag, "_d0"}, wq[base].d, 32'd0);
            chk({tag, "_a1"}, 32'(wq[base+1].a), 32'd7);
            chk({tag, "_d1"}, wq[base+1].d, k);
            chk({tag, "_a2"}, 32'(wq[base+2].a), 32'd2);
            chk({tag, "_d2"}, wq[base+2].d, 32'd0);
        end
    endtask

    int n;
    int b0;
    int stable;

    initial begin
        reset            = 1'b1;
        profile_sel      = 2'd0;
        profile_k        = {K2, K1, K0};
        locked           = 1'b1;
        mgmt_waitrequest = 1'b0;
        #1;
        chk("rst_write", 32'(mgmt_write), 32'd0);
        chk("rst_addr", 32'(mgmt_address), 32'd0);
        chk("rst_data", mgmt_writedata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_active", 32'(active_profile), 32'd0);
        chk("rst_lockerr", 32'(lock_error), 32'd0);
        step(3);
        reset = 1'b0;

        // Idle at the initial profile: nothing is written
        step(1000);
        chk("idle_writes", 32'(wq.size()), 32'd0);
        chk("idle_busy_cycles", 32'(busy_cyc), 32'd0);
        chk("idle_active", 32'(active_profile), 32'd0);

        // 0 -> 1 with no stall
        profile_sel = 2'd1;
        n = 0;
        while (mgmt_write !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        chk("p1_latency", 32'(n), 32'(SC + 3));
        chk("p1_mode_addr", 32'(mgmt_address), 32'd0);
        chk("p1_mode_hold", 32'(hold), 32'd1);
        step(1);
        chk("p1_frac_write", 32'(mgmt_write), 32'd1);
        chk("p1_frac_addr", 32'(mgmt_address), 32'd7);
        chk("p1_frac_data", mgmt_writedata, K1);
        step(1);
        chk("p1_start_addr", 32'(mgmt_address), 32'd2);
        step(1);
        chk("p1_lockmin_write", 32'(mgmt_write), 32'd0);
        chk("p1_lockmin_busy", 32'(busy), 32'd1);
        wait_idle("p1_idle_to", n);
        chk("p1_tail_cycles", 32'(n), 32'(LM + 2));
        chk("p1_active", 32'(active_profile), 32'd1);
        chk("p1_lockerr", 32'(lock_error), 32'd0);
        chk("p1_hold_low", 32'(hold), 32'd0);
        chk("p1_nwrites", 32'(wq.size()), 32'd3);
        check_seq("p1", 0, K1);
        if (wq.size() >= 3) begin
            chk("p1_consec1", 32'(wq[1].c - wq[0].c), 32'd1);
            chk("p1_consec2", 32'(wq[2].c - wq[1].c), 32'd1);
        end

        // 1 -> 2 with a five-cycle stall during FRAC
        wq.delete();
        profile_sel = 2'd2;
        wait_write("p2_write_to");
        step(1);
        mgmt_waitrequest = 1'b1;
        stable = 0;
        repeat (5) begin
            if (mgmt_write === 1'b1 && mgmt_address === 6'd7 && mgmt_writedata === K2)
                stable++;
            step(1);
        end
        mgmt_waitrequest = 1'b0;
        if (mgmt_write === 1'b1 && mgmt_address === 6'd7 && mgmt_writedata === K2)
            stable++;
        step(1);
        chk("p2_stall_stable", 32'(stable), 32'd6);
        chk("p2_start_addr", 32'(mgmt_address), 32'd2);
        wait_idle("p2_idle_to", n);
        chk("p2_active", 32'(active_profile), 32'd2);
        chk("p2_nwrites", 32'(wq.size()), 32'd3);
        check_seq("p2", 0, K2);

        // Glitch shorter than the settle window is ignored
        wq.delete();
        b0 = busy_cyc;
        profile_sel = 2'd0;
        step(SC - 1);
        profile_sel = 2'd2;
        step(30);
        chk("glitch_writes", 32'(wq.size()), 32'd0);
        chk("glitch_busy", 32'(busy_cyc - b0), 32'd0);
        chk("glitch_active", 32'(active_profile), 32'd2);

        // Out-of-range profile is ignored
        profile_sel = 2'd3;
        step(30);
        chk("invalid_writes", 32'(wq.size()), 32'd0);
        chk("invalid_busy", 32'(busy_cyc - b0), 32'd0);
        chk("invalid_active", 32'(active_profile), 32'd2);
        profile_sel = 2'd2;
        step(10);

        // Request changes mid-sequence: finish 1, then run 0 straight after
        wq.delete();
        profile_sel = 2'd1;
        wait_write("chg_write_to");
        step(1);
        profile_sel = 2'd0;
        wait_idle("chg_idle1_to", n);
        chk("chg_active1", 32'(active_profile), 32'd1);
        step(1);
        chk("chg_rebusy", 32'(busy), 32'd1);
        chk("chg_rewrite", 32'(mgmt_write), 32'd1);
        chk("chg_readdr", 32'(mgmt_address), 32'd0);
        wait_idle("chg_idle2_to", n);
        chk("chg_active2", 32'(active_profile), 32'd0);
        chk("chg_nwrites", 32'(wq.size()), 32'd6);
        check_seq("chg_a", 0, K1);
        check_seq("chg_b", 3, K0);

        // Lock never arrives: timeout flags error but still commits the profile
        wq.delete();
        locked = 1'b0;
        profile_sel = 2'd2;
        wait_write("to_write_to");
        wait_idle("to_idle_to", n);
        chk("to_busy_cycles", 32'(n), 32'(3 + LM + LT + 1));
        chk("to_lockerr", 32'(lock_error), 32'd1);
        chk("to_active", 32'(active_profile), 32'd2);
        chk("to_busy", 32'(busy), 32'd0);

        // Next successful sequence clears the sticky error
        locked = 1'b1;
        profile_sel = 2'd1;
        wait_write("clr_write_to");
        chk("clr_sticky", 32'(lock_error), 32'd1);
        wait_idle("clr_idle_to", n);
        chk("clr_lockerr", 32'(lock_error), 32'd0);
        chk("clr_active", 32'(active_profile), 32'd1);

        // Reset in the middle of FRAC
        profile_sel = 2'd2;
        wait_write("rstm_write_to");
        step(1);
        chk("rstm_frac_addr", 32'(mgmt_address), 32'd7);
        #3;
        reset = 1'b1;
        #1;
        chk("rstm_write", 32'(mgmt_write), 32'd0);
        chk("rstm_active", 32'(active_profile), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        chk("rstm_hold", 32'(hold), 32'd0);
        wq.delete();
        profile_sel = 2'd0;
        step(2);
        reset = 1'b0;
        step(30);
        chk("rstm_nwrites", 32'(wq.size()), 32'd0);
        chk("rstm_active_after", 32'(active_profile), 32'd0);
        chk("rstm_busy_after", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
